// File: rtl/rv_mem_pkg.sv
// Shared types and helpers for the rv_mem_resp memory responder.
package rv_mem_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Encoding of the request's we bit.
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // True when the byte address is word aligned and falls inside a memory
  // of 2**aw words; every bit above the word index must be zero.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return (addr[1:0] == 2'b00) && (hi == 32'd0);
  endfunction

endpackage

// File: rtl/rv_mem_array.sv
// Single-port word storage with byte-strobed writes and a registered read port.
module rv_mem_array
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // One access per enabled edge: merge strobed bytes on a write, register the word on a read.
  // NOTE: storage has no reset on purpose; clearing a RAM needs a sequencer, and the
  // read register is masked by the parent until the first good read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we == MEM_WRITE) begin
        for (int i = 0; i < 4; i++) begin
          if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/rv_mem_resp.sv
// Memory-side responder: accepts one request, waits WAIT_CYCLES cycles, then
// commits the write or returns read data with a one-cycle ready pulse.
module rv_mem_resp
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      state, state_nxt;
  logic [3:0]  cnt;

  // Captured request.
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  // Response bookkeeping.
  logic        err_q;    // error flag of the access now responding
  logic        rd_zero;  // forces rdata to 0 after reset or an error response

  // Access presented to storage on the edge that enters RESP.
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wstrb;
  logic        acc_ok;
  logic        commit;
  logic        arr_en;
  logic [31:0] arr_rdata;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and the response outputs.
  // NOTE: every signal gets a default first so no path through the case leaves
  // one unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        ready     = 1'b1;
        busy      = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the acceptance edge itself, so the
  // live inputs are used then; from WAIT the captured request is used.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = we;
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_wstrb = wstrb;
    end else begin
      acc_we    = r_we;
      acc_addr  = r_addr;
      acc_wdata = r_wdata;
      acc_wstrb = r_wstrb;
    end
    acc_ok = addr_ok(acc_addr, AW);
    commit = (state != RESP) && (state_nxt == RESP) && !rst;
    arr_en = commit && acc_ok;
  end

  // Capture the request on acceptance and run the wait-state counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 4'd0;
      r_we    <= MEM_READ;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_wstrb <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_wstrb <= wstrb;
            if (WAIT_CYCLES > 0) cnt <= 4'(WAIT_CYCLES - 1);
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Record the error status and whether rdata must read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= 1'b0;
      rd_zero <= 1'b1;
    end else if (commit) begin
      err_q <= !acc_ok;
      if (!acc_ok)                    rd_zero <= 1'b1;
      else if (acc_we == MEM_READ)    rd_zero <= 1'b0;
    end
  end

  rv_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (acc_we),
    .wstrb (acc_wstrb),
    .idx   (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  assign rdata = rd_zero ? 32'h0 : arr_rdata;

endmodule

// File: tb/tb_rv_mem_resp.sv
// Directed bench for rv_mem_resp: three instances with WAIT_CYCLES 2, 0 and 15.
module tb_rv_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  wstrb = 4'h0;
  logic        req2 = 1'b0, req0 = 1'b0, req15 = 1'b0;

  logic [31:0] rdata2, rdata0, rdata15;
  logic        ready2, ready0, ready15;
  logic        err2, err0, err15;
  logic        busy2, busy0, busy15;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv_mem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata2), .ready(ready2), .err(err2), .busy(busy2));

  rv_mem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0));

  rv_mem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(15)) dut15 (
    .clk(clk), .rst(rst), .req(req15), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata15), .ready(ready15), .err(err15), .busy(busy15));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic v);
    case (sel)
      0:       req0  = v;
      15:      req15 = v;
      default: req2  = v;
    endcase
  endtask

  function automatic logic get_ready(input int sel);
    case (sel)
      0:       return ready0;
      15:      return ready15;
      default: return ready2;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy0;
      15:      return busy15;
      default: return busy2;
    endcase
  endfunction

  function automatic logic get_err(input int sel);
    case (sel)
      0:       return err0;
      15:      return err15;
      default: return err2;
    endcase
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    case (sel)
      0:       return rdata0;
      15:      return rdata15;
      default: return rdata2;
    endcase
  endfunction

  // One complete access on instance sel (whose WAIT_CYCLES equals sel):
  // checks latency, busy window, err, rdata and the return to idle.
  task automatic access(input int sel, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic exp_err, input logic [31:0] exp_rd, input string tag);
    int  lat;
    int  n_busy;
    bit  seen;
    @(negedge clk);
    we = w; addr = a; wdata = d; wstrb = s;
    set_req(sel, 1'b1);
    seen = 1'b0; lat = 0; n_busy = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) set_req(sel, 1'b0);
      if (get_busy(sel)) n_busy++;
      if (get_ready(sel)) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(sel + 1));
    check({tag, " busy_cycles"}, 32'(n_busy), 32'(sel + 1));
    check({tag, " err"}, {31'b0, get_err(sel)}, {31'b0, exp_err});
    check({tag, " rdata"}, get_rdata(sel), exp_rd);
    @(negedge clk);
    check({tag, " idle_after"}, {30'b0, get_ready(sel), get_busy(sel)}, 32'h0);
  endtask

  initial begin
    int n_rdy;
    int n_late;

    // Write/read, strobes, errors and boundary words on the 2-wait-state instance.
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEAA};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF, 1'b0, 32'hDEAD_BEAA};
    vecs[5]  = '{1'b0, 32'h0000_0002, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEAA};
    vecs[7]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0000_0000};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b0, 32'h1122_3344};
    vecs[9]  = '{1'b1, 32'h0000_0010, 32'h5566_0000, 4'hC, 1'b0, 32'h1122_3344};
    vecs[10] = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h1122_3344};
    vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'h5566_BEAA};
    vecs[12] = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h5566_BEAA};
    vecs[13] = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0, 1'b0, 32'hA5A5_A5A5};
    vecs[14] = '{1'b0, 32'h0000_03FD, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    vecs[15] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    vecs[16] = '{1'b1, 32'h0000_03FE, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
    vecs[17] = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0, 1'b0, 32'hA5A5_A5A5};

    // Reset values, during and after reset.
    repeat (3) @(negedge clk);
    check("reset dut2", {rdata2, 1'b0} ^ {31'b0, ready2, err2} ^ {31'b0, busy2}, 32'h0);
    check("reset dut0 rdata", rdata0, 32'h0);
    check("reset dut0 flags", {29'b0, ready0, err0, busy0}, 32'h0);
    check("reset dut15 flags", {29'b0, ready15, err15, busy15}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset dut2 rdata", rdata2, 32'h0);
    check("post_reset dut2 flags", {29'b0, ready2, err2, busy2}, 32'h0);

    for (int i = 0; i < 18; i++) begin
      access(2, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
             vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));
    end

    // req raised during WAIT (with changed inputs) is ignored; the original read is served.
    @(negedge clk);
    we = 1'b0; addr = 32'h10; wdata = 32'h0; wstrb = 4'h0; req2 = 1'b1;
    n_rdy = 0; n_late = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) begin
        we = 1'b1; wdata = 32'h0; wstrb = 4'hF;
      end
      if (n == 2) req2 = 1'b0;
      if (ready2) begin
        n_rdy++;
        if (n != 3) n_late++;
        check("ignore rdata", rdata2, 32'h5566_BEAA);
      end
    end
    check("ignore ready_count", 32'(n_rdy), 32'd1);
    check("ignore ready_cycle", 32'(n_late), 32'd0);
    access(2, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h5566_BEAA, "ignore readback");

    // Zero wait states: seed four words, then hold req for back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      access(0, 1'b1, 32'(i * 4), 32'h100 + 32'(i), 4'hF, 1'b0, 32'h0, $sformatf("seed%0d", i));
    end
    @(negedge clk);
    we = 1'b0; wstrb = 4'h0; addr = 32'h0; req0 = 1'b1;
    n_rdy = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      addr = 32'((n % 4) * 4);
      if (ready0) n_rdy++;
      if (n % 2 == 1) begin
        check($sformatf("b2b ready n%0d", n), {31'b0, ready0}, 32'h1);
        check($sformatf("b2b rdata n%0d", n), rdata0, 32'h100 + 32'((n - 1) % 4));
      end else begin
        check($sformatf("b2b idle n%0d", n), {31'b0, ready0}, 32'h0);
      end
    end
    req0 = 1'b0;
    check("b2b ready_count", 32'(n_rdy), 32'd4);
    @(negedge clk);
    check("b2b stop", {30'b0, ready0, busy0}, 32'h0);

    // Reset during WAIT drops the pending write.
    access(2, 1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h5566_BEAA, "rst_seed");
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; wstrb = 4'hF; req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    check("rst_mid busy_before", {31'b0, busy2}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_mid rdata", rdata2, 32'h0);
    check("rst_mid flags", {29'b0, ready2, err2, busy2}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_rdy = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ready2 || busy2) n_rdy++;
    end
    check("rst_mid no_response", 32'(n_rdy), 32'd0);
    access(2, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0BAD_F00D, "rst_readback");

    // Fifteen wait states.
    access(15, 1'b1, 32'h40, 32'h0F0F_1234, 4'hF, 1'b0, 32'h0, "w15 write");
    access(15, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h0F0F_1234, "w15 read");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_mem_resp.md
Name: rv_mem_resp

Overview:
- Memory-side responder for the multicycle RISC-V core: a single-port word memory behind a request/ready handshake with a programmable number of wait states.
- Accepts one read or write per request, registers the address, write data and byte strobes, counts wait states, then commits the write or returns read data together with a one-cycle ready pulse.
- Flags misaligned and out-of-range accesses with err.
- Sits between the core's memory interface (address mux and write-data mux outputs, write strobe) and the storage array.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of 2, minimum 4.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and response; legal range 0..15.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- req  input  1  request valid, sampled only in IDLE
- we  input  1  1 = write, 0 = read; sampled with req
- addr  input  32  byte address; sampled with req
- wdata  input  32  write data; sampled with req
- wstrb  input  4  byte enables, bit i → wdata[8i+7:8i]; sampled with req
- rdata  output  32  read data; valid when ready=1 and err=0, held until the next response
- ready  output  1  one-cycle response pulse
- err  output  1  access error; valid only with ready, otherwise 0
- busy  output  1  high from the cycle after acceptance through the ready cycle

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values: state IDLE, wait counter 0, ready=0, err=0, busy=0, rdata=32'h0, request registers 0.
  - Storage contents are not reset.
  - A reset mid-operation drops the pending access; no write is committed.
- State machine (enum, 3 states):
  - IDLE: if req=1, capture we/addr/wdata/wstrb. Go to WAIT if WAIT_CYCLES>0 (counter ← WAIT_CYCLES-1), else go to RESP. Otherwise stay in IDLE.
  - WAIT: counter decrements each cycle. When counter==0, go to RESP.
  - RESP: ready=1 and busy=1 for exactly this cycle; next state is IDLE unconditionally.
- Latency: with req high in cycle k, ready is high in cycle k+1+WAIT_CYCLES. A new request is accepted earliest in cycle k+2+WAIT_CYCLES, i.e. the cycle after ready.
- req while busy (WAIT or RESP) is ignored and not queued. The requester holds req low until it sees ready.
- Error check, on the registered address:
  - err = (addr[1:0] != 2'b00) OR (addr[31:AW+2] != 0), where AW = $clog2(DEPTH_WORDS).
  - On error: no write, rdata ← 32'h0, err=1 with ready.
- Write commit, at the clock edge entering RESP (registered we=1, no error): for each i with wstrb[i]=1, mem[addr[AW+1:2]] byte i ← wdata byte i. Other bytes are unchanged. wstrb=4'b0000 is a legal no-op write that still responds. rdata is unchanged on writes.
- Read, at the same edge (we=0, no error): rdata ← mem[addr[AW+1:2]]. Word read only; wstrb is ignored.
- The counter is 4 bits wide and never wraps; it is reloaded only on acceptance.
- Storage is addressed only by the registered address, so input changes after acceptance have no effect.

Decomposition:
- Package rv_mem_pkg:
  - state typedef (IDLE=0, WAIT=1, RESP=2)
  - localparams MEM_READ=1'b0, MEM_WRITE=1'b1
  - function for the aligned/in-range check
- Sub-module rv_mem_array:
  - DEPTH_WORDS x 32 storage
  - synchronous byte-strobed write, synchronous read into the output register
  - ports: clk, en, we, wstrb[3:0], idx[AW-1:0], wdata, rdata
- Top rv_mem_resp holds the FSM, counter, request registers and error logic.

Test Plan:
- Write then read, WAIT_CYCLES=2: req=1, we=1, addr=32'h10, wdata=32'hDEADBEEF, wstrb=4'hF in cycle 0 → ready in cycle 3 with err=0. Then a read of 32'h10 → rdata=32'hDEADBEEF with ready 3 cycles after its req.
- Byte strobes: after the word above, write addr=32'h10, wdata=32'h000000AA, wstrb=4'b0001 → a subsequent read of 32'h10 returns 32'hDEADBEAA.
- Errors, DEPTH_WORDS=256:
  - Read at addr=32'h2 → ready with err=1, rdata=0.
  - Write at addr=32'h400 → ready with err=1; a subsequent read of 32'h0 is unchanged.
- Busy ignore and back-to-back: hold req=1 continuously with WAIT_CYCLES=0 → ready every 2nd cycle, exactly one access per ready. A req asserted during WAIT is not served.
- Reset mid-write: accept a write of 32'h12345678 to 32'h20, assert rst in the WAIT state → ready never pulses and all outputs are 0. After release, a read of 32'h20 returns the old value.
- WAIT_CYCLES=15: a read responds exactly 16 cycles after req; busy is high for the 16 cycles in between.
